// File: rtl/cla_word_seq_if.sv
// rtl/cla_word_seq_if.sv - byte-wide link between the word sequencer and an 8-bit CLA slice
//
// Signals:
//   x, y  - operand bytes presented to the adder
//   c     - carry-in presented to the adder
//   s     - byte sum returned by the adder (combinational from x, y, c)
//   c12   - byte carry-out returned by the adder
// Modports:
//   master - sequencer side (drives x/y/c, consumes s/c12)
//   slave  - adder side (consumes x/y/c, drives s/c12)
interface cla_word_seq_if;
    logic [7:0] x;
    logic [7:0] y;
    logic       c;
    logic [7:0] s;
    logic       c12;

    modport master (output x, y, c, input s, c12);
    modport slave  (input x, y, c, output s, c12);
endinterface

// File: rtl/cla_word_seq.sv
// rtl/cla_word_seq.sv - multi-cycle WORDS*8-bit adder built around an external 8-bit CLA slice
//
// Adds a + b + cin one byte per clock, least significant byte first, chaining
// the slice carry between beats. The result is held until the next accepted start.
//
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   start            - request a new addition (accepted when not busy)
//   a, b, cin        - operands and initial carry, latched when start is accepted
//   adder (master)   - x/y/c out to the CLA slice, s/c12 back from it
//   busy             - high while beats are in progress
//   done             - one-cycle pulse when sum/cout are valid
//   sum, cout        - registered result and final carry-out
module cla_word_seq #(
    parameter int WORDS = 4,
    parameter int IW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*WORDS-1:0]   a,
    input  logic [8*WORDS-1:0]   b,
    input  logic                 cin,
    cla_word_seq_if.master       adder,
    output logic                 busy,
    output logic                 done,
    output logic [8*WORDS-1:0]   sum,
    output logic                 cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic                 carry_reg;
    logic [8*WORDS-1:0]   a_reg;
    logic [8*WORDS-1:0]   b_reg;
    logic                 last_beat;

    assign last_beat = (idx == IW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (start && state != ADD) begin
            // Accepted from IDLE or DONE; DONE->ADD gives back-to-back operations.
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            state     <= ADD;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                ADD: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx == IW'(i)) begin
                            sum[8*i +: 8] <= adder.s;
                        end
                    end
                    carry_reg <= adder.c12;
                    if (last_beat) begin
                        cout  <= adder.c12;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The adder inputs are muxed from the latched operands; they idle at zero
    // outside ADD so the slice sees no activity between operations.
    always_comb begin
        adder.x = '0;
        adder.y = '0;
        adder.c = 1'b0;
        if (state == ADD) begin
            adder.c = carry_reg;
            for (int i = 0; i < WORDS; i++) begin
                if (idx == IW'(i)) begin
                    adder.x = a_reg[8*i +: 8];
                    adder.y = b_reg[8*i +: 8];
                end
            end
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_cla_word_seq.sv
// tb/tb_cla_word_seq.sv - self-checking bench for cla_word_seq
module tb_cla_word_seq;
    localparam int WORDS = 4;
    localparam int IW    = 3;
    localparam int W     = 8 * WORDS;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [W-1:0]   sum;
    logic           cout;

    int passed = 0;
    int total  = 0;

    cla_word_seq_if adder_bus ();

    // Behavioural stand-in for the 8-bit CLA slice.
    assign {adder_bus.c12, adder_bus.s} = {1'b0, adder_bus.x} + {1'b0, adder_bus.y} + 9'(adder_bus.c);

    cla_word_seq #(.WORDS(WORDS), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .adder (adder_bus.master),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W:0] model_add(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    endfunction

    // Carry into byte i = overflow of the low 8*i bits of a + b + cin.
    function automatic logic carry_into(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc, input int i);
        logic [W:0] m;
        logic [W:0] t;
        m = ((W+1)'(1) << (8 * i)) - (W+1)'(1);
        t = ({1'b0, ma} & m) + ({1'b0, mb} & m) + (W+1)'(mc);
        t = t >> (8 * i);
        return t[0];
    endfunction

    function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int i);
        logic [W-1:0] sh;
        sh = v >> (8 * i);
        return sh[7:0];
    endfunction

    // Runs one operation; returns at the falling edge inside the DONE cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input string name);
        int  beats;
        bit  got;
        @(posedge clk); #1;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        beats = 0;
        got   = 0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
            end else if (busy) begin
                if (beats < WORDS) begin
                    check({name, " x"}, adder_bus.x, byte_of(ta, beats));
                    check({name, " y"}, adder_bus.y, byte_of(tb_, beats));
                    check({name, " c"}, adder_bus.c, carry_into(ta, tb_, tc, beats));
                end
                beats++;
            end
        end
        check({name, " done seen"}, got, 1);
        check({name, " beats"}, beats, WORDS);
        check({name, " sum"}, sum, exp_sum);
        check({name, " cout"}, cout, exp_cout);
        check({name, " xyc idle in done"}, {adder_bus.x, adder_bus.y, adder_bus.c}, 0);
    endtask

    initial begin
        vec_t       vecs[6];
        logic [W:0] m;
        logic [W-1:0] a0, b0, a1, b1;
        logic       c1;
        int         n;
        bit         got;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        check("reset xyc", {adder_bus.x, adder_bus.y, adder_bus.c}, 0);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            a0 = W'($urandom); b0 = W'($urandom); c1 = 1'($urandom);
            m  = model_add(a0, b0, c1);
            run_op(a0, b0, c1, m[W-1:0], m[W], $sformatf("rand%0d", i));
        end

        // Back-to-back: start issued during DONE of the previous operation.
        run_op(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, "b2b first");
        a = 32'h80000000; b = 32'h80000000; cin = 1'b0; start = 1'b1;
        check("b2b prev sum in done", sum, 32'h33333333);
        check("b2b done in prev", done, 1);
        @(posedge clk); #1;
        start = 1'b0; a = '1; b = '1;
        n = 1; got = 0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(posedge clk); n++; #1;
            if (done) got = 1;
        end
        check("b2b done seen", got, 1);
        check("b2b latency edges", n, 5);
        check("b2b sum", sum, 0);
        check("b2b cout", cout, 1);

        // Start held high while operands change every cycle.
        @(posedge clk); #1;
        a0 = W'($urandom); b0 = W'($urandom);
        a = a0; b = b0; cin = 1'b0; start = 1'b1;
        got = 0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1;
                m = model_add(a0, b0, 1'b0);
                check("hold sum", sum, m[W-1:0]);
                check("hold cout", cout, m[W]);
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (got) begin a1 = a; b1 = b; c1 = cin; end
        end
        check("hold done seen", got, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("hold restart no idle", busy, 1);
        got = 0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        m = model_add(a1, b1, c1);
        check("hold second done", got, 1);
        check("hold second sum", sum, m[W-1:0]);
        check("hold second cout", cout, m[W]);

        // Reset in the 2nd ADD cycle aborts the operation.
        @(posedge clk); #1;
        a = 32'hDEADBEEF; b = 32'h01020304; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort busy before reset", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        got = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done || busy) got = 1;
        end
        check("abort no done pulse", got, 0);
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, "after abort");

        // Start and reset together: reset wins.
        @(posedge clk); #1;
        a = 32'h12345678; b = 32'h1; start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        check("reset beats start busy", busy, 0);
        check("reset beats start sum", sum, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
